// File: rtl/nn_pkg.sv
// Shared datapath package: score widths, class count, score vector type and
// the argmax FSM state encoding.
package nn_pkg;

  localparam int DATA_W    = 32;
  localparam int N_CLASSES = 10;
  localparam int IDX_W     = 4;

  typedef logic signed [DATA_W-1:0] score_t;
  typedef score_t [0:N_CLASSES-1]   score_vec_t;

  typedef enum logic [1:0] {
    ARGMAX_IDLE = 2'd0,
    ARGMAX_SCAN = 2'd1,
    ARGMAX_DONE = 2'd2
  } argmax_state_t;

endpackage

// File: rtl/output_argmax_if.sv
// Handshake/result bundle between the output layer and the argmax stage.
// The margin field exists only when OUTPUT_ARGMAX_MARGIN_EN is defined.
interface output_argmax_if
  import nn_pkg::*;
#(
  parameter int DATA_W    = nn_pkg::DATA_W,
  parameter int N_CLASSES = nn_pkg::N_CLASSES,
  parameter int IDX_W     = nn_pkg::IDX_W
);

  logic                              start;
  logic [0:N_CLASSES-1][DATA_W-1:0]  scores_in;
  logic                              busy;
  logic                              done;
  logic [IDX_W-1:0]                  class_out;
  logic signed [DATA_W-1:0]          max_score;
`ifdef OUTPUT_ARGMAX_MARGIN_EN
  logic [DATA_W-1:0]                 margin;

  modport master (output start, scores_in,
                  input  busy, done, class_out, max_score, margin);
  modport slave  (input  start, scores_in,
                  output busy, done, class_out, max_score, margin);
`else
  modport master (output start, scores_in,
                  input  busy, done, class_out, max_score);
  modport slave  (input  start, scores_in,
                  output busy, done, class_out, max_score);
`endif

endinterface

// File: rtl/argmax_update.sv
// One step of the running maximum: folds a candidate score into best/index
// (and second-best when OUTPUT_ARGMAX_MARGIN_EN is defined).
module argmax_update
  import nn_pkg::*;
#(
  parameter int DATA_W = nn_pkg::DATA_W,
  parameter int IDX_W  = nn_pkg::IDX_W
) (
  input  logic signed [DATA_W-1:0] best,
  input  logic [IDX_W-1:0]         best_idx,
  input  logic signed [DATA_W-1:0] cand,
  input  logic [IDX_W-1:0]         cand_idx,
`ifdef OUTPUT_ARGMAX_MARGIN_EN
  input  logic signed [DATA_W-1:0] second,
  output logic signed [DATA_W-1:0] next_second,
`endif
  output logic signed [DATA_W-1:0] next_best,
  output logic [IDX_W-1:0]         next_idx
);

  // Strict greater-than so ties keep the earlier (lower) index.
  always_comb begin
    next_best = best;
    next_idx  = best_idx;
`ifdef OUTPUT_ARGMAX_MARGIN_EN
    next_second = second;
`endif
    if (cand > best) begin
      next_best = cand;
      next_idx  = cand_idx;
`ifdef OUTPUT_ARGMAX_MARGIN_EN
      next_second = best;
`endif
    end else begin
      next_best = best;
      next_idx  = best_idx;
`ifdef OUTPUT_ARGMAX_MARGIN_EN
      if (cand > second) begin
        next_second = cand;
      end else begin
        next_second = second;
      end
`endif
    end
  end

endmodule

// File: rtl/output_argmax.sv
// Final classification stage: snapshots the output-layer scores and scans them
// one per clock for the winning class. Option: OUTPUT_ARGMAX_MARGIN_EN.
module output_argmax
  import nn_pkg::*;
#(
  parameter int N_CLASSES = nn_pkg::N_CLASSES,
  parameter int DATA_W    = nn_pkg::DATA_W,
  parameter int IDX_W     = nn_pkg::IDX_W
) (
  input  logic            clk,
  input  logic            rstn,
  output_argmax_if.slave  bus
);

  localparam logic [1:0] IDLE = ARGMAX_IDLE;
  localparam logic [1:0] SCAN = ARGMAX_SCAN;
  localparam logic [1:0] DONE = ARGMAX_DONE;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CLASSES - 1);

  logic [1:0]               state_r;
  logic [IDX_W-1:0]         idx_r;
  logic signed [DATA_W-1:0] snap_r [0:N_CLASSES-1];
  logic signed [DATA_W-1:0] best_r;
  logic [IDX_W-1:0]         best_idx_r;
  logic                     busy_r;
  logic                     done_r;
  logic [IDX_W-1:0]         class_r;
  logic signed [DATA_W-1:0] max_score_r;
  logic signed [DATA_W-1:0] next_best_s;
  logic [IDX_W-1:0]         next_idx_s;
  logic                     capture_s;

`ifdef OUTPUT_ARGMAX_MARGIN_EN
  localparam logic signed [DATA_W-1:0] SCORE_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  logic signed [DATA_W-1:0] second_r;
  logic signed [DATA_W-1:0] next_second_s;
  logic [DATA_W-1:0]        margin_r;

  // Difference taken one bit wider so extreme score pairs cannot wrap.
  function automatic logic [DATA_W-1:0] sat_margin(input logic signed [DATA_W-1:0] b,
                                                   input logic signed [DATA_W-1:0] s);
    logic signed [DATA_W:0] diff;
    diff = {b[DATA_W-1], b} - {s[DATA_W-1], s};
    if (diff[DATA_W]) begin
      sat_margin = {DATA_W{1'b0}};
    end else if (diff[DATA_W-1]) begin
      sat_margin = {1'b0, {(DATA_W-1){1'b1}}};
    end else begin
      sat_margin = diff[DATA_W-1:0];
    end
  endfunction
`endif

  assign capture_s = bus.start && ((state_r == IDLE) || (state_r == DONE));

  argmax_update #(
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_update (
    .best        (best_r),
    .best_idx    (best_idx_r),
    .cand        (snap_r[idx_r]),
    .cand_idx    (idx_r),
`ifdef OUTPUT_ARGMAX_MARGIN_EN
    .second      (second_r),
    .next_second (next_second_s),
`endif
    .next_best   (next_best_s),
    .next_idx    (next_idx_s)
  );

  // FSM, snapshot capture, running best and registered result outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r     <= IDLE;
      idx_r       <= {IDX_W{1'b0}};
      best_r      <= {DATA_W{1'b0}};
      best_idx_r  <= {IDX_W{1'b0}};
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      class_r     <= {IDX_W{1'b0}};
      max_score_r <= {DATA_W{1'b0}};
      for (int i = 0; i < N_CLASSES; i++) begin
        snap_r[i] <= {DATA_W{1'b0}};
      end
`ifdef OUTPUT_ARGMAX_MARGIN_EN
      second_r    <= {DATA_W{1'b0}};
      margin_r    <= {DATA_W{1'b0}};
`endif
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE, DONE: begin
          if (capture_s) begin
            for (int i = 0; i < N_CLASSES; i++) begin
              snap_r[i] <= $signed(bus.scores_in[i]);
            end
            best_r     <= $signed(bus.scores_in[0]);
            best_idx_r <= {IDX_W{1'b0}};
            idx_r      <= IDX_W'(1);
`ifdef OUTPUT_ARGMAX_MARGIN_EN
            second_r   <= SCORE_MIN;
`endif
            busy_r     <= 1'b1;
            state_r    <= SCAN;
          end else begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        SCAN: begin
          best_r     <= next_best_s;
          best_idx_r <= next_idx_s;
`ifdef OUTPUT_ARGMAX_MARGIN_EN
          second_r   <= next_second_s;
`endif
          idx_r      <= idx_r + IDX_W'(1);
          if (idx_r == LAST_IDX) begin
            class_r     <= next_idx_s;
            max_score_r <= next_best_s;
`ifdef OUTPUT_ARGMAX_MARGIN_EN
            margin_r    <= sat_margin(next_best_s, next_second_s);
`endif
            done_r      <= 1'b1;
            busy_r      <= 1'b0;
            state_r     <= DONE;
          end else begin
            busy_r  <= 1'b1;
            state_r <= SCAN;
          end
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.class_out = class_r;
  assign bus.max_score = max_score_r;
`ifdef OUTPUT_ARGMAX_MARGIN_EN
  assign bus.margin    = margin_r;
`endif

endmodule

// File: tb/tb_output_argmax.sv
// Directed-vector bench for output_argmax; margin checks are enabled when
// OUTPUT_ARGMAX_MARGIN_EN is defined.
module tb_output_argmax;
  import nn_pkg::*;

  logic clk;
  logic rstn;
  int   n_cmp;
  int   n_err;

  output_argmax_if #(.DATA_W(32), .N_CLASSES(10), .IDX_W(4)) bus ();

  output_argmax #(.N_CLASSES(10), .DATA_W(32), .IDX_W(4)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic set_all(input logic [31:0] v);
    for (int i = 0; i < 10; i++) bus.scores_in[i] = v;
  endtask

  // Called 1 time unit after a rising edge; start is seen at the next edge.
  task automatic pulse_start();
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  // Counts edges until done is observed, bounded so a stuck DUT cannot hang.
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!bus.done && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic check_result(input string tag, input int cyc, input logic [3:0] cls,
                              input logic [31:0] mx, input logic [31:0] mg);
    check_val({tag, "_latency"}, 32'(cyc), 32'd9);
    check_val({tag, "_done"}, {31'd0, bus.done}, 32'd1);
    check_val({tag, "_class"}, {28'd0, bus.class_out}, {28'd0, cls});
    check_val({tag, "_max"}, bus.max_score, mx);
`ifdef OUTPUT_ARGMAX_MARGIN_EN
    check_val({tag, "_margin"}, bus.margin, mg);
`else
    if (mg == 32'hFFFF_FFFF) $display("unexpected margin sentinel");
`endif
  endtask

  int cyc;
  int done_seen;

  initial begin
    n_cmp = 0;
    n_err = 0;
    rstn = 1'b0;
    bus.start = 1'b0;
    set_all(32'd0);
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_busy", {31'd0, bus.busy}, 32'd0);
    check_val("rst_done", {31'd0, bus.done}, 32'd0);
    check_val("rst_class", {28'd0, bus.class_out}, 32'd0);
    check_val("rst_max", bus.max_score, 32'd0);
    rstn = 1'b1;
    @(posedge clk); #1;

    // Ascending scores
    for (int i = 0; i < 10; i++) bus.scores_in[i] = 32'(i);
    pulse_start();
    check_val("asc_busy", {31'd0, bus.busy}, 32'd1);
    wait_done(cyc);
    check_result("asc", cyc, 4'd9, 32'd9, 32'd1);
    check_val("asc_busy_done", {31'd0, bus.busy}, 32'd0);
    @(posedge clk); #1;
    check_val("asc_pulse", {31'd0, bus.done}, 32'd0);
    check_val("asc_hold", {28'd0, bus.class_out}, 32'd9);

    // Signed compare
    set_all(-32'sd5);
    bus.scores_in[3] = -32'sd1;
    pulse_start();
    wait_done(cyc);
    check_result("neg", cyc, 4'd3, 32'hFFFF_FFFF - 32'd0, 32'd4);

    // Tie keeps lower index
    set_all(32'd0);
    bus.scores_in[2] = 32'd100;
    bus.scores_in[7] = 32'd100;
    pulse_start();
    wait_done(cyc);
    check_result("tie", cyc, 4'd2, 32'd100, 32'd0);

    // Extremes: margin saturates
    set_all(32'h8000_0000);
    bus.scores_in[5] = 32'h7FFF_FFFF;
    pulse_start();
    wait_done(cyc);
    check_result("ext", cyc, 4'd5, 32'h7FFF_FFFF, 32'h7FFF_FFFF);

    // Mid-scan start ignored; snapshot isolates later input changes
    for (int i = 0; i < 10; i++) bus.scores_in[i] = 32'(i);
    pulse_start();
    repeat (3) begin @(posedge clk); #1; end
    for (int i = 0; i < 10; i++) bus.scores_in[i] = 32'(50 - i);
    pulse_start();
    set_all(32'd7);
    wait_done(cyc);
    check_val("mid_latency", 32'(cyc), 32'd5);
    check_val("mid_class", {28'd0, bus.class_out}, 32'd9);
    check_val("mid_max", bus.max_score, 32'd9);

    // Back-to-back: start asserted during the DONE cycle
    for (int i = 0; i < 10; i++) bus.scores_in[i] = 32'(20 - i);
    pulse_start();
    check_val("b2b_busy", {31'd0, bus.busy}, 32'd1);
    wait_done(cyc);
    check_result("b2b", cyc, 4'd0, 32'd20, 32'd1);

    // Reset during scan
    for (int i = 0; i < 10; i++) bus.scores_in[i] = 32'(i);
    pulse_start();
    repeat (4) begin @(posedge clk); #1; end
    rstn = 1'b0;
    #1;
    check_val("rstmid_busy", {31'd0, bus.busy}, 32'd0);
    check_val("rstmid_class", {28'd0, bus.class_out}, 32'd0);
    check_val("rstmid_max", bus.max_score, 32'd0);
    done_seen = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (bus.done) done_seen++;
    end
    rstn = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      if (bus.done) done_seen++;
    end
    check_val("rstmid_nodone", 32'(done_seen), 32'd0);
    check_val("rstmid_idle_max", bus.max_score, 32'd0);
    set_all(-32'sd5);
    bus.scores_in[3] = -32'sd1;
    pulse_start();
    wait_done(cyc);
    check_result("post", cyc, 4'd3, 32'hFFFF_FFFF, 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/output_argmax.md
# output_argmax

Final classification stage of the network datapath. Sits directly downstream of the 10-neuron hidden/output layer and consumes its 10 signed 32-bit neuron scores once that layer's done-status asserts. Snapshots the scores, scans them sequentially one per clock, and reports the winning class index and its score with a one-cycle done pulse.

## Interface
- `N_CLASSES`, 10: number of scores to scan. Must be at least 2.
- `DATA_W`, 32: signed score width.
- `IDX_W`, 4: class index width. Must satisfy 2^IDX_W >= N_CLASSES.
- `clk`  in  1  single clock; all logic is rising-edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `start`  in  1  capture request; driven by the upstream layer's counter done-status.
- `scores_in`  in  signed [DATA_W-1:0] [0:N_CLASSES-1]  neuron outputs from the upstream layer.
- `busy`  out  1  high while a scan is in progress.
- `done`  out  1  single-cycle pulse; result outputs are valid from this cycle onward.
- `class_out`  out  [IDX_W-1:0]  index of the maximum score.
- `max_score`  out  signed [DATA_W-1:0]  maximum score value.
- `margin`  out  [DATA_W-1:0]  (best − second best), saturated. Present only with `OUTPUT_ARGMAX_MARGIN_EN`.

## Operation
- States: IDLE, SCAN, DONE.
- IDLE:
  - When `start`=1 is sampled, copy all of `scores_in` into an internal snapshot array.
  - Set best = snapshot[0], best_idx = 0, idx = 1; go to SCAN.
  - Upstream may change `scores_in` freely after the capture edge.
- SCAN, each clock:
  - Compare snapshot[idx] against best using a signed compare with strict `>`. Ties keep the lower index.
  - If greater, update best and best_idx.
  - Increment idx.
  - On the edge that processes idx = N_CLASSES−1: register `class_out` / `max_score` (and `margin`) from the final values and go to DONE.
- DONE:
  - `done` = 1 for exactly this one cycle.
  - If `start` = 1 here, capture and enter SCAN (back-to-back operation). Otherwise go to IDLE.
- `start` is ignored in SCAN. It is not queued.
- `busy` = 1 in SCAN only.
- Result outputs hold their value until the next DONE overwrites them.
- All compares are full DATA_W signed. No truncation or rescaling of scores.

## Timing
- Reset value of all outputs is 0. State resets to IDLE and the snapshot array is cleared.
- Latency: with `start` sampled at edge E0, `done` is high in the cycle after edge E(N_CLASSES−1). For N=10 that is 9 clocks after E0.
- Throughput: one classification per N_CLASSES cycles when `start` is asserted in DONE.
- Reset asserted mid-scan: the scan is abandoned immediately, no `done` is emitted, and outputs return to 0.
- `start` held high continuously: a new capture occurs in each IDLE or DONE cycle.

## Configuration
- `OUTPUT_ARGMAX_MARGIN_EN` defined:
  - Additionally tracks second-best. Its initial value at capture is the most negative DATA_W value.
  - On a new maximum, second takes the old best. Otherwise, if score > second, second takes the score.
  - `margin` = best − second, computed at DATA_W+1 bits and saturated to 2^(DATA_W−1)−1.
  - Registered and updated together with `class_out`.
- Not defined: the second-best logic and the `margin` port are absent. All other behaviour is identical.

## Structure
- Shared package `nn_pkg` holds:
  - `DATA_W` and `N_CLASSES` defaults;
  - the typedef for the signed score vector;
  - the state enum `argmax_state_t` (IDLE/SCAN/DONE).
- One sub-module, `argmax_update`: purely combinational. It takes the current best/second/index plus a candidate and produces the next best/second/index. The second-best path is present only under the macro.
- The FSM, snapshot array and index counter live in the top module.

## Test plan
- Ascending scores 0,1,…,9 with `start` pulsed → `done` 9 clocks later; `class_out`=9, `max_score`=9; with macro, `margin`=1.
- All scores −5 except index 3 = −1 → `class_out`=3, `max_score`=−1. Confirms the compare is signed.
- Scores index 2 = 100 and index 7 = 100, all others 0 → `class_out`=2 (tie keeps lower index); with macro, `margin`=0.
- Scores −2^31 at index 0 and 2^31−1 at index 5 → `class_out`=5; with macro, `margin` saturates to 0x7FFF_FFFF.
- `start` pulsed again mid-scan with different scores → ignored; the result reflects the first snapshot. `start` asserted in DONE → second result arrives 9 cycles after that DONE.
- `rstn` dropped at scan cycle 4 → no `done`, all outputs read 0. After release, a new `start` produces a correct result.
